mem_port_arbiter: RTL and testbench

Shares one single-ported, fixed-latency memory between the CPU's instruction-fetch port and its data-memory port, so the pipeline can run against a unified memory. Each requester uses a req/gnt/rvalid handshake. The arbiter owns all memory control signals and sequences each access through issue, wait and response. It sits between the CPU top level and the memory macro.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_sat_cnt.sv | 21 ++
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Requester identifiers, also used as the value of the winner/last_loser flags.
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  // Out of reset, dm is recorded as the last loser so dm wins the first contention.
  localparam logic LAST_LOSER_RST = REQ_DM;

endpackage

// File: rtl/mem_arb_sat_cnt.sv
// mem_arb_sat_cnt: 32-bit counter that increments while en is high and sticks at all-ones.
// Only built when MEMARB_PERF_CNT_EN is defined; nothing else uses it.
`ifdef MEMARB_PERF_CNT_EN
module mem_arb_sat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] cnt
);

  // Count enabled cycles, holding at the maximum value instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en && (cnt != 32'hFFFF_FFFF)) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported memory between the
// instruction-fetch (if) and data (dm) ports. Each access runs ISSUE -> WAIT -> RESP;
// RESP overlaps the next arbitration so back-to-back reads cost MEM_LAT+2 cycles.
// Optional feature macro MEMARB_PERF_CNT_EN adds perf_if_wait/perf_dm_wait counters.
//
// state | meaning
// IDLE  | arbitrate among pending requests
// ISSUE | drive registered command for one cycle, pulse winner's gnt
// WAIT  | count down until mem_rdata is due, capture it on cnt==0
// RESP  | pulse winner's rvalid and arbitrate again
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic [DATA_W/8-1:0] dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
`ifdef MEMARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_if_wait,
  output logic [31:0]         perf_dm_wait
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              last_loser, last_loser_nxt;
  logic              sel, sel_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [BE_W-1:0]   we_q, we_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              capture;
  logic              contended;
  logic              winner;

  // Fetch only wins a contended arbitration if it lost the previous one.
  assign contended = if_req && dm_req;
  assign winner    = contended ? ((last_loser == REQ_IF) ? REQ_IF : REQ_DM)
                               : (dm_req ? REQ_DM : REQ_IF);

  // State, command and arbitration-history registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_loser <= LAST_LOSER_RST;
      sel        <= REQ_IF;
      addr_q     <= '0;
      we_q       <= '0;
      wdata_q    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_loser <= last_loser_nxt;
      sel        <= sel_nxt;
      addr_q     <= addr_nxt;
      we_q       <= we_nxt;
      wdata_q    <= wdata_nxt;
    end
  end

  // Per-requester read data, held between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (capture) begin
      if (sel == REQ_DM) dm_rdata_q <= mem_rdata;
      else               if_rdata_q <= mem_rdata;
    end
  end

  // Next-state, arbitration and output decode.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_loser_nxt = last_loser;
    sel_nxt        = sel;
    addr_nxt       = addr_q;
    we_nxt         = we_q;
    wdata_nxt      = wdata_q;
    capture        = 1'b0;
    if_gnt         = 1'b0;
    dm_gnt         = 1'b0;
    if_rvalid      = 1'b0;
    dm_rvalid      = 1'b0;
    mem_en         = 1'b0;
    mem_we         = '0;
    mem_addr       = '0;
    mem_wdata      = '0;

    case (state)
      IDLE, RESP: begin
        if (state == RESP) begin
          if (sel == REQ_DM) dm_rvalid = 1'b1;
          else               if_rvalid = 1'b1;
        end
        if (if_req || dm_req) begin
          sel_nxt   = winner;
          addr_nxt  = (winner == REQ_DM) ? dm_addr : if_addr;
          we_nxt    = (winner == REQ_DM) ? dm_we : '0;
          wdata_nxt = (winner == REQ_DM) ? dm_wdata : '0;
          if (contended) last_loser_nxt = ~winner;
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (sel == REQ_DM) dm_gnt = 1'b1;
        else               if_gnt = 1'b1;
        if (|we_q) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = CNT_W'(MEM_LAT - 1);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign busy     = (state != IDLE);

`ifdef MEMARB_PERF_CNT_EN
  mem_arb_sat_cnt u_if_cnt (
    .clk (clk),
    .rst (rst),
    .en  (if_req && !if_gnt),
    .cnt (perf_if_wait)
  );

  mem_arb_sat_cnt u_dm_cnt (
    .clk (clk),
    .rst (rst),
    .en  (dm_req && !dm_gnt),
    .cnt (perf_dm_wait)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (MEM_LAT=2 main instance,
// MEM_LAT=1 second instance). Perf-counter checks compile only with MEMARB_PERF_CNT_EN.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int OW = 6 + 3 * DW + AW + BW;

  typedef struct packed {
    logic          who;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic [BW-1:0] dm_we = '0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt, dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy;
  logic [OW-1:0] outs_all;

  logic          l1_dm_req = 1'b0;
  logic [AW-1:0] l1_dm_addr = '0;
  logic          l1_if_gnt, l1_if_rvalid, l1_dm_gnt, l1_dm_rvalid;
  logic [DW-1:0] l1_if_rdata, l1_dm_rdata;
  logic          l1_mem_en;
  logic [BW-1:0] l1_mem_we;
  logic [AW-1:0] l1_mem_addr;
  logic [DW-1:0] l1_mem_wdata, l1_mem_rdata;
  logic          l1_busy;

`ifdef MEMARB_PERF_CNT_EN
  logic [31:0] perf_if_wait, perf_dm_wait, l1_perf_if, l1_perf_dm;
`endif

  assign outs_all = {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, busy,
                     if_rdata, dm_rdata, mem_wdata, mem_addr, mem_we};

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEMARB_PERF_CNT_EN
    , .perf_if_wait(perf_if_wait), .perf_dm_wait(perf_dm_wait)
`endif
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(32'h0), .if_gnt(l1_if_gnt), .if_rvalid(l1_if_rvalid), .if_rdata(l1_if_rdata),
    .dm_req(l1_dm_req), .dm_we(4'b0000), .dm_addr(l1_dm_addr), .dm_wdata(32'h0),
    .dm_gnt(l1_dm_gnt), .dm_rvalid(l1_dm_rvalid), .dm_rdata(l1_dm_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .busy(l1_busy)
`ifdef MEMARB_PERF_CNT_EN
    , .perf_if_wait(l1_perf_if), .perf_dm_wait(l1_perf_dm)
`endif
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Fixed-latency memory models: data appears MEM_LAT cycles after the mem_en cycle.
  logic          rv0 = 1'b0, rv1 = 1'b0, l1_rv0 = 1'b0;
  logic [AW-1:0] ra0 = '0, ra1 = '0, l1_ra0 = '0;
  always @(posedge clk) begin
    rv0    <= mem_en && (mem_we == '0);
    ra0    <= mem_addr;
    rv1    <= rv0;
    ra1    <= ra0;
    l1_rv0 <= l1_mem_en && (l1_mem_we == '0);
    l1_ra0 <= l1_mem_addr;
  end
  assign mem_rdata    = rv1 ? mem_fn(ra1) : '0;
  assign l1_mem_rdata = l1_rv0 ? mem_fn(l1_ra0) : '0;

  exp_t          exp_q[$];
  exp_t          exp1_q[$];
  int            en_count = 0;
  int            l1_rv_count = 0;
  logic [AW-1:0] lc_addr = '0;
  logic [BW-1:0] lc_we = '0;
  logic [DW-1:0] lc_wdata = '0;
  logic [1:0]    lc_gnt = '0;

  // Main-instance scoreboard: every rvalid must match the oldest expected response.
  always @(negedge clk) begin : mon_main
    exp_t e;
    if (mem_en) begin
      en_count++;
      lc_addr  = mem_addr;
      lc_we    = mem_we;
      lc_wdata = mem_wdata;
      lc_gnt   = {if_gnt, dm_gnt};
    end
    if (if_rvalid || dm_rvalid) begin
      total++;
      if (if_rvalid && dm_rvalid) begin
        bad++;
        $display("FAIL rvalid_route: both rvalids high, required one");
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rvalid_unexpected: if_rvalid=%0b dm_rvalid=%0b, required no response", if_rvalid, dm_rvalid);
      end else begin
        e = exp_q.pop_front();
        if ((dm_rvalid ? REQ_DM : REQ_IF) !== e.who || (dm_rvalid ? dm_rdata : if_rdata) !== e.data) begin
          bad++;
          $display("FAIL rvalid_data: got who=%0b data=%h, required who=%0b data=%h",
                   dm_rvalid, (dm_rvalid ? dm_rdata : if_rdata), e.who, e.data);
        end
      end
    end
  end

  // MEM_LAT=1 instance scoreboard.
  always @(negedge clk) begin : mon_lat1
    exp_t e;
    if (l1_dm_rvalid || l1_if_rvalid) begin
      total++;
      l1_rv_count++;
      if (l1_if_rvalid || exp1_q.size() == 0) begin
        bad++;
        $display("FAIL lat1_rvalid_unexpected: if_rvalid=%0b queued=%0d", l1_if_rvalid, exp1_q.size());
      end else begin
        e = exp1_q.pop_front();
        if (l1_dm_rdata !== e.data) begin
          bad++;
          $display("FAIL lat1_rdata: got %h, required %h", l1_dm_rdata, e.data);
        end
      end
    end
  end

  task automatic push_exp(input logic who, input logic [AW-1:0] addr);
    exp_t e;
    e.who  = who;
    e.data = mem_fn(addr);
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  // One read with the arbiter idle; reports the grant and rvalid cycles (req = cycle 0).
  task automatic idle_read(input logic who, input logic [AW-1:0] addr, output int gnt_at, output int rv_at);
    gnt_at = -1;
    rv_at  = -1;
    @(posedge clk); #1;
    if (who == REQ_DM) begin
      dm_req = 1'b1; dm_we = '0; dm_addr = addr;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    push_exp(who, addr);
    for (int k = 0; k < 20 && rv_at < 0; k++) begin
      @(negedge clk);
      if (who == REQ_DM ? dm_rvalid : if_rvalid) rv_at = k;
      if (gnt_at < 0 && (who == REQ_DM ? dm_gnt : if_gnt)) begin
        gnt_at = k;
        @(posedge clk); #1;
        dm_req = 1'b0;
        if_req = 1'b0;
      end
    end
    dm_req = 1'b0;
    if_req = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (outs_all !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, required 0", outs_all);
    end
`ifdef MEMARB_PERF_CNT_EN
    total++;
    if ({perf_if_wait, perf_dm_wait} !== 64'h0) begin
      bad++;
      $display("FAIL reset_perf: got %h/%h, required 0/0", perf_if_wait, perf_dm_wait);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_single_fetch();
    int g, r, n0;
    n0 = en_count;
    idle_read(REQ_IF, 32'h10, g, r);
    total++;
    if (g !== 1 || r !== 4) begin
      bad++;
      $display("FAIL fetch_latency: got gnt=%0d rvalid=%0d, required gnt=1 rvalid=4", g, r);
    end
    @(negedge clk);
    total++;
    if ({en_count - n0, lc_addr, lc_we, lc_gnt} !== {32'd1, 32'h10, 4'b0000, 2'b10}) begin
      bad++;
      $display("FAIL fetch_cmd: got en=%0d addr=%h we=%b gnt=%b, required en=1 addr=10 we=0000 gnt=10",
               en_count - n0, lc_addr, lc_we, lc_gnt);
    end
    total++;
    if (if_rdata !== 32'hDEAD_BEEF || if_rvalid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL fetch_hold: got rdata=%h rvalid=%b busy=%b, required deadbeef 0 0", if_rdata, if_rvalid, busy);
    end
  endtask

  task automatic test_data_write();
    int n0;
    n0 = en_count;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 4'b0011; dm_addr = 32'h200; dm_wdata = 32'h1234;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (dm_gnt !== 1'b1 || mem_en !== 1'b1) begin
      bad++;
      $display("FAIL write_gnt: got dm_gnt=%b mem_en=%b in cycle 1, required 1 1", dm_gnt, mem_en);
    end
    @(posedge clk); #1;
    dm_req = 1'b0; dm_we = '0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL write_busy: got %b in cycle 2, required 0", busy);
    end
    repeat (4) @(negedge clk);
    total++;
    if ({en_count - n0, lc_addr, lc_we, lc_wdata, lc_gnt} !== {32'd1, 32'h200, 4'b0011, 32'h1234, 2'b01}) begin
      bad++;
      $display("FAIL write_cmd: got en=%0d addr=%h we=%b wdata=%h gnt=%b, required en=1 addr=200 we=0011 wdata=1234 gnt=01",
               en_count - n0, lc_addr, lc_we, lc_wdata, lc_gnt);
    end
  endtask

  task automatic test_contention();
    int         g_cyc[4];
    logic [1:0] g_pair[4];
    int         ng;
`ifdef MEMARB_PERF_CNT_EN
    logic [31:0] base;
    logic        first_if;
    first_if = 1'b1;
`endif
    ng = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = '0; dm_addr = 32'h300;
    push_exp(REQ_DM, 32'h300);
    push_exp(REQ_IF, 32'h40);
    push_exp(REQ_DM, 32'h300);
    push_exp(REQ_IF, 32'h40);
`ifdef MEMARB_PERF_CNT_EN
    @(negedge clk);
    base = perf_if_wait;
    for (int k = 1; k < 40 && ng < 4; k++) begin
`else
    for (int k = 0; k < 40 && ng < 4; k++) begin
`endif
      @(negedge clk);
      if (if_gnt || dm_gnt) begin
        g_cyc[ng]  = k;
        g_pair[ng] = {if_gnt, dm_gnt};
        ng++;
`ifdef MEMARB_PERF_CNT_EN
        if (if_gnt && first_if) begin
          first_if = 1'b0;
          total++;
          if (perf_if_wait - base !== 32'd5) begin
            bad++;
            $display("FAIL perf_if_wait: got %0d, required 5", perf_if_wait - base);
          end
        end
`endif
        if (ng == 4) begin
          @(posedge clk); #1;
          if_req = 1'b0;
          dm_req = 1'b0;
        end
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    total++;
    if (ng !== 4) begin
      bad++;
      $display("FAIL contention_count: got %0d grants, required 4", ng);
    end
    for (int i = 0; i < ng; i++) begin
      total++;
      if (g_cyc[i] !== 1 + 4 * i || g_pair[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        bad++;
        $display("FAIL contention_grant%0d: got cycle=%0d if/dm=%b, required cycle=%0d if/dm=%b",
                 i, g_cyc[i], g_pair[i], 1 + 4 * i, ((i % 2 == 0) ? 2'b01 : 2'b10));
      end
    end
    wait_idle();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL contention_drain: got %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_read();
    int g, r;
    // Contended start leaves last_loser = if before the reset.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h44;
    dm_req = 1'b1; dm_we = '0; dm_addr = 32'h500;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({if_gnt, dm_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL midrd_first_gnt: got if/dm=%b, required 01", {if_gnt, dm_gnt});
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midrd_wait_busy: got %b, required 1", busy);
    end
    rst = 1'b0;
    #1;
    total++;
    if (outs_all !== '0) begin
      bad++;
      $display("FAIL midrd_async_reset: got %h, required 0", outs_all);
    end
`ifdef MEMARB_PERF_CNT_EN
    total++;
    if ({perf_if_wait, perf_dm_wait} !== 64'h0) begin
      bad++;
      $display("FAIL midrd_perf_reset: got %h/%h, required 0/0", perf_if_wait, perf_dm_wait);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL midrd_after_busy: got %b, required 0", busy);
    end
    // last_loser must be back to dm, so dm wins again.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h48;
    dm_req = 1'b1; dm_we = '0; dm_addr = 32'h600;
    push_exp(REQ_DM, 32'h600);
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({if_gnt, dm_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL midrd_last_loser: got if/dm=%b, required 01", {if_gnt, dm_gnt});
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    dm_req = 1'b0;
    wait_idle();
    idle_read(REQ_IF, 32'h10, g, r);
    total++;
    if (g !== 1 || r !== 4) begin
      bad++;
      $display("FAIL midrd_next_latency: got gnt=%0d rvalid=%0d, required gnt=1 rvalid=4", g, r);
    end
    wait_idle();
  endtask

  task automatic test_lat1_back_to_back();
    int   g_cyc[4];
    int   ng;
    exp_t e;
    ng = 0;
    @(posedge clk); #1;
    l1_dm_req  = 1'b1;
    l1_dm_addr = 32'h700;
    e.who = REQ_DM; e.data = mem_fn(32'h700);
    exp1_q.push_back(e);
    for (int k = 0; k < 40 && ng < 4; k++) begin
      @(negedge clk);
      if (l1_dm_gnt) begin
        g_cyc[ng] = k;
        ng++;
        @(posedge clk); #1;
        if (ng == 4) begin
          l1_dm_req = 1'b0;
        end else begin
          l1_dm_addr = 32'h700 + 32'(4 * ng);
          e.data     = mem_fn(l1_dm_addr);
          exp1_q.push_back(e);
        end
      end
    end
    l1_dm_req = 1'b0;
    total++;
    if (ng !== 4) begin
      bad++;
      $display("FAIL lat1_count: got %0d grants, required 4", ng);
    end
    for (int i = 0; i < ng; i++) begin
      total++;
      if (g_cyc[i] !== 1 + 3 * i) begin
        bad++;
        $display("FAIL lat1_grant%0d: got cycle %0d, required %0d", i, g_cyc[i], 1 + 3 * i);
      end
    end
    repeat (6) @(negedge clk);
    total++;
    if (l1_rv_count !== 4 || exp1_q.size() !== 0 || l1_busy !== 1'b0) begin
      bad++;
      $display("FAIL lat1_drain: got responses=%0d outstanding=%0d busy=%b, required 4 0 0",
               l1_rv_count, exp1_q.size(), l1_busy);
    end
    total++;
    if ({l1_if_gnt, l1_if_rdata, l1_mem_we, l1_mem_wdata} !== '0) begin
      bad++;
      $display("FAIL lat1_if_quiet: got gnt=%b rdata=%h we=%b wdata=%h, required all 0",
               l1_if_gnt, l1_if_rdata, l1_mem_we, l1_mem_wdata);
    end
  endtask

  task automatic test_perf_sat();
`ifdef MEMARB_PERF_CNT_EN
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = '0; dm_addr = 32'h800;
    push_exp(REQ_DM, 32'h800);
    force u_dut.u_if_cnt.cnt = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    dm_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h84;
    push_exp(REQ_IF, 32'h84);
    @(negedge clk);
    release u_dut.u_if_cnt.cnt;
    @(negedge clk);
    total++;
    if (perf_if_wait !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL perf_reach_max: got %h, required ffffffff", perf_if_wait);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (perf_if_wait !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL perf_saturate: got %h, required ffffffff", perf_if_wait);
    end
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (if_gnt) seen = 1'b1;
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    wait_idle();
`endif
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at 200us, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_data_write();
    test_contention();
    test_reset_mid_read();
    test_lat1_back_to_back();
    test_perf_sat();
    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL final_drain: got %0d responses outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
